// File: rtl/div_radix2.sv
// div_radix2: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per cycle and delivers {remainder, quotient}
// as the 64-bit {HI, LO} write word. Divide by zero short-circuits to a
// fixed {a, all-ones} result without iterating.
module div_radix2 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic        cancel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic [32:0] p_q;        // partial remainder
    logic [31:0] q_q;        // dividend shifting out / quotient shifting in
    logic [31:0] div_q;      // divisor magnitude
    logic        qsign_q;
    logic        rsign_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [63:0] result_q;

    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic [32:0] p_sh_s;
    logic [32:0] trial_s;
    logic [32:0] p_d;
    logic [31:0] q_d;
    logic [31:0] quo_fin_s;
    logic [31:0] rem_fin_s;

    // Operand magnitudes taken at accept time; unsigned ops pass through.
    always_comb begin
        if (signed_div_i && a_i[31]) begin
            a_abs_s = 32'd0 - a_i;
        end else begin
            a_abs_s = a_i;
        end
        if (signed_div_i && b_i[31]) begin
            b_abs_s = 32'd0 - b_i;
        end else begin
            b_abs_s = b_i;
        end
    end

    // One restoring step plus the sign-corrected final values of that step.
    always_comb begin
        p_sh_s  = {p_q[31:0], q_q[31]};
        trial_s = p_sh_s - {1'b0, div_q};
        if (!trial_s[32]) begin
            p_d = trial_s;
            q_d = {q_q[30:0], 1'b1};
        end else begin
            p_d = p_sh_s;
            q_d = {q_q[30:0], 1'b0};
        end
        if (qsign_q) begin
            quo_fin_s = 32'd0 - q_d;
        end else begin
            quo_fin_s = q_d;
        end
        if (rsign_q) begin
            rem_fin_s = 32'd0 - p_d[31:0];
        end else begin
            rem_fin_s = p_d[31:0];
        end
    end

    // Control FSM and datapath registers; result is written on FINISH entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            p_q      <= 33'd0;
            q_q      <= 32'd0;
            div_q    <= 32'd0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
        end else if (cancel_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        p_q     <= 33'd0;
                        q_q     <= a_abs_s;
                        div_q   <= b_abs_s;
                        qsign_q <= signed_div_i & (a_i[31] ^ b_i[31]);
                        rsign_q <= signed_div_i & a_i[31];
                        cnt_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        if (b_i == 32'd0) begin
                            state_q  <= S_FINISH;
                            result_q <= {a_i, 32'hFFFF_FFFF};
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q  <= S_FINISH;
                        result_q <= {rem_fin_s, quo_fin_s};
                        done_q   <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed table, random vectors against
// an arithmetic reference model, and hand-written cancel/reset sequences.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sd;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks;
    int failures;

    div_radix2 dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .signed_div_i(sd),
        .cancel_i    (cancel),
        .a_i         (a),
        .b_i         (b),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS truncating division from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit s);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and check result, latency, busy span and done pulse width.
    task automatic do_div(input string name, input logic [31:0] x, input logic [31:0] y,
                          input bit s, input logic [63:0] exp);
        int  lat;
        int  bcnt;
        bit  got;
        int  exp_lat;
        logic [63:0] res;
        exp_lat = (y == 32'd0) ? 1 : 33;
        a = x; b = y; sd = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; bcnt = 0; got = 1'b0; res = 64'd0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (busy) bcnt++;
            if (done) begin
                got = 1'b1;
                res = result;
            end else begin
                tick();
                lat++;
            end
        end
        if (!got) lat = -1;
        chk({name, "_result"}, res, exp);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        tick();
        if (busy) bcnt++;
        chk({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] prior;
        bit          seen;
        logic [31:0] ra, rb;
        bit          rs;

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; sd = 1'b0; cancel = 1'b0; a = 32'd0; b = 32'd0;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000};
        vecs[4]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF};
        vecs[5]  = '{32'h1234_5678,  32'd0,          1'b0, 64'h12345678_FFFFFFFF};
        vecs[6]  = '{32'h1234_5678,  32'd0,          1'b1, 64'h12345678_FFFFFFFF};
        vecs[7]  = '{32'd15,         32'd4,          1'b0, 64'h00000003_00000003};
        vecs[8]  = '{32'd9,          32'd3,          1'b0, 64'h00000000_00000003};
        vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'h00000000_00000001};
        vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 64'h80000000_00000000};
        vecs[11] = '{32'd7,          32'hFFFF_FFFE,  1'b0, 64'h00000007_00000000};

        // Reset state
        #12;
        chk("reset_busy",   {63'd0, busy}, 64'd0);
        chk("reset_done",   {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
        end

        // Random vectors against reference model
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(1, 15);
                1: rb = 32'd0;
                2: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            do_div($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs));
        end

        // Cancel mid-CALC: no done, result retained, busy drops next cycle
        do_div("pre_cancel", 32'd15, 32'd4, 1'b0, 64'h00000003_00000003);
        prior = result;
        a = 32'd100; b = 32'd7; sd = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy_low", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        chk("cancel_no_done", {63'd0, seen}, 64'd0);
        chk("cancel_result_kept", result, prior);
        do_div("after_cancel", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

        // start and cancel together: start dropped
        a = 32'd100; b = 32'd7; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done) seen = 1'b1;
            tick();
        end
        chk("start_cancel_no_busy", {63'd0, seen}, 64'd0);

        // start while busy is ignored
        a = 32'd100; b = 32'd7; sd = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        a = 32'd9; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        chk("busy_start_done", {63'd0, seen}, 64'd1);
        chk("busy_start_result", result, 64'h00000002_0000000E);
        tick();
        tick();
        chk("busy_start_no_second_op", {63'd0, busy}, 64'd0);

        // Async reset mid-CALC, between clock edges
        a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy",   {63'd0, busy}, 64'd0);
        chk("async_rst_done",   {63'd0, done}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        do_div("after_reset", 32'd15, 32'd4, 1'b0, 64'h00000003_00000003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
